pipeline_trace_buffer: RTL
==========================

# pipeline_trace_buffer

- Synthesizable retire-trace monitor for the pipelined core; replaces per-cycle bench printing with a buffered commit record.
- Captures one record per retired instruction (PC, instruction word, register write-back) into a parametrised circular buffer, drained through a valid/ready port.
- Keeps saturating performance counters (cycles, retires, stalls, flushes, dropped records).
- Raises a sticky halt after a configurable retire count, so benches stop on retired work instead of a fixed cycle count.

## Interface

- XLEN, 64, register/PC data width
- DEPTH, 16, trace entries; power of two, >= 2
- CNT_W, 32, width of every performance counter
- MAX_RETIRE, 20, retire count that raises halt; 0 disables halt
- OVERWRITE, 0, full-buffer policy: 0 drop the new record, 1 overwrite the oldest
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  capture/count enable
- ret_valid  input  1  an instruction retires this cycle (WB stage)
- ret_pc  input  XLEN  PC of retiring instruction
- ret_inst  input  32  instruction word
- ret_rd_we  input  1  retiring instruction writes rd
- ret_rd_addr  input  5  destination register
- ret_rd_data  input  XLEN  write-back value
- stall  input  1  any of IF/ID stall active this cycle
- flush  input  1  EX flush active this cycle
- tr_valid  output  1  head record available
- tr_ready  input  1  consumer accepts head record
- tr_pc, tr_inst, tr_rd_we, tr_rd_addr, tr_rd_data  output  XLEN/32/1/5/XLEN  head record fields
- occupancy  output  $clog2(DEPTH+1)  stored records
- cycle_cnt, retire_cnt, stall_cnt, flush_cnt, drop_cnt  output  CNT_W each  counters
- halt  output  1  sticky: retire_cnt reached MAX_RETIRE

## Operation

- **Capture.** Push when en && ret_valid && !halt.
  - Record = {pc, inst, rd_we, rd_addr, rd_data}.
  - ret_rd_data is stored as presented, even if ret_rd_addr is 0.
- **Pop.** Occurs when tr_valid && tr_ready; head pointer advances.
- **Full, OVERWRITE=0:**
  - Push without a same-cycle pop is discarded; drop_cnt += 1.
  - Push with a same-cycle pop is accepted; occupancy unchanged.
- **Full, OVERWRITE=1:**
  - Push without a pop overwrites the oldest; head advances; drop_cnt += 1.
  - Push with a pop: the pop consumes the current head, the push takes the freed slot, drop_cnt unchanged.
- **Empty:** push and tr_ready in the same cycle do not bypass; the record appears on the next cycle.
- **Pointers:** log2(DEPTH) bits each, wrap modulo DEPTH; full/empty decided by occupancy.
- **Counters** (every one saturates at all-ones; none wraps):
  - cycle_cnt += 1 every cycle with en && !halt.
  - retire_cnt += 1 per accepted-or-dropped retire.
  - stall_cnt and flush_cnt increment on en && !halt && the respective input.
- **Halt:**
  - Sets on the edge where retire_cnt becomes MAX_RETIRE.
  - Clears only on rst.
  - While halt is high, capture and all counters freeze; draining continues.
- **en low:** freezes capture and counters; draining continues.
- **Reset** (all outputs 0):
  - Pointers, occupancy, tr_valid, all counters and halt clear.
  - Record fields clear to 0.
  - Reset mid-drain discards contents; tr_valid is 0 the following cycle.

## Timing

- Capture latency 1: a record pushed at edge N drives tr_valid from N+1 onward.
- tr_* fields are a registered/memory read of head; stable while tr_valid && !tr_ready.
- tr_valid never drops without a pop or rst.
- occupancy, counters and halt update on the same edge as the triggering event.
- Simultaneous push/pop on a non-full, non-empty buffer leaves occupancy unchanged.
- Throughput: one push and one pop per cycle.

## Test plan

- **Basic retire.** After rst, retire 3 records (pc 0x0/0x4/0x8, rd x1..x3 = 5/10/15) with tr_ready=0.
  - Expect occupancy=3, retire_cnt=3.
  - Then tr_ready=1: records emerge in order over 3 cycles, then tr_valid=0.
- **Drop policy.** DEPTH=4, OVERWRITE=0, tr_ready=0, 6 retires.
  - Expect occupancy=4, drop_cnt=2.
  - Drain yields the first four PCs.
- **Overwrite policy.** DEPTH=4, OVERWRITE=1, same stimulus.
  - Expect drop_cnt=2.
  - Drain yields PCs 0x8..0x14.
- **Halt.** MAX_RETIRE=20, continuous retires.
  - halt rises on the 20th.
  - retire_cnt stays 20 and cycle_cnt freezes.
  - A 21st ret_valid is not captured.
- **Saturation and counts.** CNT_W=4, 20 cycles of stall=1, flush pulsed on 3 cycles.
  - Expect stall_cnt=15 (saturated) and flush_cnt=3.
- **Full boundary and reset.**
  - Full buffer with simultaneous push+pop: occupancy stays DEPTH and drop_cnt is unchanged.
  - Assert rst mid-drain: next cycle tr_valid=0, occupancy=0, every counter=0 and halt=0.

Source files
------------

// File: rtl/pipeline_trace_buffer.sv
// rtl/pipeline_trace_buffer.sv - retire-trace circular buffer with saturating perf counters and retire-count halt
module pipeline_trace_buffer #(
  parameter int XLEN       = 64,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int MAX_RETIRE = 20,
  parameter bit OVERWRITE  = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       ret_valid,
  input  logic [XLEN-1:0]            ret_pc,
  input  logic [31:0]                ret_inst,
  input  logic                       ret_rd_we,
  input  logic [4:0]                 ret_rd_addr,
  input  logic [XLEN-1:0]            ret_rd_data,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       tr_valid,
  input  logic                       tr_ready,
  output logic [XLEN-1:0]            tr_pc,
  output logic [31:0]                tr_inst,
  output logic                       tr_rd_we,
  output logic [4:0]                 tr_rd_addr,
  output logic [XLEN-1:0]            tr_rd_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [CNT_W-1:0]           retire_cnt,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       halt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int REC_W = XLEN + 32 + 1 + 5 + XLEN;
  localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, retire_q, retire_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d, drop_q, drop_d;
  logic             halt_q, halt_d;
  logic             active, push, pop, full, wr_en, drop_inc;
  logic [REC_W-1:0] head_rec;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && v != CNT_MAX) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    active   = en && !halt_q;
    push     = active && ret_valid;
    pop      = (occ_q != '0) && tr_ready;
    full     = (occ_q == OCC_W'(DEPTH));
    head_d   = head_q;
    tail_d   = tail_q;
    occ_d    = occ_q;
    wr_en    = 1'b0;
    drop_inc = 1'b0;
    // When full the tail aliases the head, so an accepted write lands in the slot being vacated.
    if (push && (!full || pop || OVERWRITE)) begin
      wr_en  = 1'b1;
      tail_d = tail_q + PTR_W'(1);
    end
    if (push && full && !pop) drop_inc = 1'b1;
    if (pop || (drop_inc && OVERWRITE)) head_d = head_q + PTR_W'(1);
    if (wr_en && !pop && !full) occ_d = occ_q + OCC_W'(1);
    else if (pop && !wr_en) occ_d = occ_q - OCC_W'(1);

    cycle_d  = sat_inc(cycle_q, active);
    retire_d = sat_inc(retire_q, push);
    stall_d  = sat_inc(stall_q, active && stall);
    flush_d  = sat_inc(flush_q, active && flush);
    drop_d   = sat_inc(drop_q, drop_inc);
    halt_d   = halt_q || ((MAX_RETIRE != 0) && push && (CMP_W'(retire_d) == CMP_W'(MAX_RETIRE)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      occ_q    <= '0;
      cycle_q  <= '0;
      retire_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
      drop_q   <= '0;
      halt_q   <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      occ_q    <= occ_d;
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      drop_q   <= drop_d;
      halt_q   <= halt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[tail_q] <= {ret_pc, ret_inst, ret_rd_we, ret_rd_addr, ret_rd_data};
  end

  // Storage is not reset, so the head fields are forced to zero whenever nothing is held.
  assign tr_valid = (occ_q != '0);
  assign head_rec = tr_valid ? mem_q[head_q] : '0;
  assign {tr_pc, tr_inst, tr_rd_we, tr_rd_addr, tr_rd_data} = head_rec;

  assign occupancy  = occ_q;
  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;
  assign drop_cnt   = drop_q;
  assign halt       = halt_q;
endmodule
